// File: rtl/mygo_fifo_pkg.sv
// Shared helpers and types for the Go channel FIFO.
// Sizing functions stay valid for degenerate depths (0 and 1).
package mygo_fifo_pkg;

    // Ceiling log2 that never returns less than 1, so vectors keep a width.
    function automatic int safe_clog2(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

    // Pointer width for a buffer of the given depth.
    function automatic int addr_bits_for(input int depth);
        return safe_clog2(depth);
    endfunction

    // Occupancy counter width, which must be able to hold the value DEPTH itself.
    function automatic int count_bits_for(input int depth);
        return safe_clog2(depth + 1);
    endfunction

    typedef enum logic [1:0] {
        CH_OPEN    = 2'd0,
        CH_CLOSING = 2'd1,
        CH_CLOSED  = 2'd2
    } chan_state_e;

endpackage

// File: rtl/mygo_fifo_mem.sv
// Storage array for the channel FIFO. It has one synchronous write port
// and a combinational read port.
module mygo_fifo_mem
    import mygo_fifo_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 2,
    parameter int ADDR_BITS = addr_bits_for(DEPTH)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [WIDTH-1:0]     rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Payload storage needs no reset because out_valid gates every read.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mygo_chan_fifo.sv
// Go channel FIFO with close() semantics. DEPTH=0 builds an unbuffered rendezvous channel.
// Optional macro MYGO_CHAN_HWM_EN adds a sticky high-water-mark output named hwm.
module mygo_chan_fifo
    import mygo_fifo_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 2,
    parameter int REG_READY  = 1,
    parameter int COUNT_BITS = count_bits_for(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_close,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_closed,
    output logic [COUNT_BITS-1:0] count
`ifdef MYGO_CHAN_HWM_EN
    ,
    output logic [COUNT_BITS-1:0] hwm
`endif
);

    localparam int ADDR_BITS = addr_bits_for(DEPTH);
    localparam logic [COUNT_BITS-1:0] DEPTH_C = COUNT_BITS'(DEPTH);

    // Handshake: a transfer happens on a side in any cycle where valid and ready
    // are both high. A producer holds in_data stable while in_valid waits for in_ready.
    logic                  push;
    logic                  pop;
    logic                  closed;
    chan_state_e           state_q;
    chan_state_e           state_d;
    logic [COUNT_BITS-1:0] count_q;
    logic [COUNT_BITS-1:0] count_d;

    assign push   = in_valid & in_ready;
    assign pop    = out_valid & out_ready;
    assign closed = (state_q != CH_OPEN);

    generate
        if (DEPTH == 0) begin : g_rdv
            // No storage here. The producer and consumer meet in the same cycle.
            assign out_valid = in_valid & ~closed;
            assign out_data  = in_data;
            assign in_ready  = out_ready & ~closed;
            assign count_d   = '0;
        end else begin : g_buf
            localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(DEPTH - 1);

            logic [ADDR_BITS-1:0] wptr_q;
            logic [ADDR_BITS-1:0] rptr_q;

            if (REG_READY != 0) begin : g_reg_ready
                assign in_ready = ~closed & (count_q < DEPTH_C);
            end else begin : g_comb_ready
                // A full buffer still accepts a push when the head leaves in the same cycle.
                assign in_ready = ~closed & ((count_q < DEPTH_C) | out_ready);
            end

            assign out_valid = (count_q != '0);

            always_comb begin
                count_d = count_q;
                if (push && !pop) begin
                    count_d = count_q + 1'b1;
                end else if (pop && !push) begin
                    count_d = count_q - 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    wptr_q <= '0;
                    rptr_q <= '0;
                end else begin
                    if (push) begin
                        wptr_q <= (wptr_q == LAST_ADDR) ? '0 : wptr_q + 1'b1;
                    end
                    if (pop) begin
                        rptr_q <= (rptr_q == LAST_ADDR) ? '0 : rptr_q + 1'b1;
                    end
                end
            end

            mygo_fifo_mem #(
                .WIDTH     (WIDTH),
                .DEPTH     (DEPTH),
                .ADDR_BITS (ADDR_BITS)
            ) u_mem (
                .clk   (clk),
                .we    (push),
                .waddr (wptr_q),
                .wdata (in_data),
                .raddr (rptr_q),
                .rdata (out_data)
            );
        end
    endgenerate

    // A push that coincides with in_close is enqueued first, so the channel then closes behind it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            CH_OPEN: begin
                if (in_close) begin
                    state_d = (count_q == '0 && !push) ? CH_CLOSED : CH_CLOSING;
                end
            end
            CH_CLOSING: begin
                if (count_q == '0) begin
                    state_d = CH_CLOSED;
                end
            end
            default: state_d = CH_CLOSED;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= CH_OPEN;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign count      = count_q;
    assign out_closed = closed & (count_q == '0);

`ifdef MYGO_CHAN_HWM_EN
    logic [COUNT_BITS-1:0] hwm_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hwm_q <= '0;
        end else if (count_d > hwm_q) begin
            hwm_q <= count_d;
        end
    end

    assign hwm = hwm_q;
`endif

endmodule

// File: tb/tb_mygo_chan_fifo.sv
// Self-checking bench for mygo_chan_fifo covering DEPTH=4/REG_READY=1, DEPTH=2/REG_READY=0 and DEPTH=0.
// hwm is checked as well when MYGO_CHAN_HWM_EN is defined.
module tb_mygo_chan_fifo;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_close;
    logic         out_ready;

    logic ir4, ov4, oc4, ir2, ov2, oc2, ir0, ov0, oc0;
    logic [W-1:0] od4, od2, od0;
    logic [2:0]   cnt4;
    logic [1:0]   cnt2;
    logic [0:0]   cnt0;
`ifdef MYGO_CHAN_HWM_EN
    logic [2:0]   hwm4;
    logic [1:0]   hwm2;
    logic [0:0]   hwm0;
`endif

    always #5 clk = ~clk;

    mygo_chan_fifo #(.WIDTH(W), .DEPTH(4), .REG_READY(1)) u_d4 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(ir4),
        .in_close(in_close), .out_data(od4), .out_valid(ov4), .out_ready(out_ready),
        .out_closed(oc4), .count(cnt4)
`ifdef MYGO_CHAN_HWM_EN
        , .hwm(hwm4)
`endif
    );

    mygo_chan_fifo #(.WIDTH(W), .DEPTH(2), .REG_READY(0)) u_d2 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(ir2),
        .in_close(in_close), .out_data(od2), .out_valid(ov2), .out_ready(out_ready),
        .out_closed(oc2), .count(cnt2)
`ifdef MYGO_CHAN_HWM_EN
        , .hwm(hwm2)
`endif
    );

    mygo_chan_fifo #(.WIDTH(W), .DEPTH(0), .REG_READY(1)) u_d0 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(ir0),
        .in_close(in_close), .out_data(od0), .out_valid(ov0), .out_ready(out_ready),
        .out_closed(oc0), .count(cnt0)
`ifdef MYGO_CHAN_HWM_EN
        , .hwm(hwm0)
`endif
    );

    // Selects which instance is observed.
    int           sel;
    logic         o_ir, o_ov, o_oc;
    logic [W-1:0] o_od;
    logic [7:0]   o_cnt, o_hwm;

    always_comb begin
        o_ir = ir4; o_ov = ov4; o_oc = oc4; o_od = od4; o_cnt = 8'(cnt4); o_hwm = '0;
`ifdef MYGO_CHAN_HWM_EN
        o_hwm = 8'(hwm4);
`endif
        if (sel == 1) begin
            o_ir = ir2; o_ov = ov2; o_oc = oc2; o_od = od2; o_cnt = 8'(cnt2);
`ifdef MYGO_CHAN_HWM_EN
            o_hwm = 8'(hwm2);
`endif
        end else if (sel == 2) begin
            o_ir = ir0; o_ov = ov0; o_oc = oc0; o_od = od0; o_cnt = 8'(cnt0);
`ifdef MYGO_CHAN_HWM_EN
            o_hwm = 8'(hwm0);
`endif
        end
    end

    // Reference model state.
    int           m_depth;
    bit           m_regready;
    bit           m_closed;
    int           m_hwm;
    logic [W-1:0] exp_q[$];
    int           n_checks = 0;
    int           n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Check one cycle against the model, then advance past the next rising edge.
    task automatic tick(output bit pushed);
        bit exp_ir, exp_ov, pop;
        #1;
        if (m_depth == 0) begin
            exp_ir = out_ready && !m_closed;
            exp_ov = in_valid && !m_closed;
        end else begin
            exp_ir = !m_closed && ((exp_q.size() < m_depth) || (!m_regready && out_ready));
            exp_ov = exp_q.size() != 0;
        end
        check("in_ready", 64'(o_ir), 64'(exp_ir));
        check("out_valid", 64'(o_ov), 64'(exp_ov));
        check("out_closed", 64'(o_oc), 64'(m_closed && exp_q.size() == 0));
        check("count", 64'(o_cnt), 64'(exp_q.size()));
`ifdef MYGO_CHAN_HWM_EN
        check("hwm", 64'(o_hwm), 64'(m_hwm));
`endif
        pushed = in_valid && exp_ir;
        pop    = exp_ov && out_ready;
        if (m_depth == 0) begin
            if (exp_ov) check("rdv_data", 64'(o_od), 64'(in_data));
        end else begin
            if (exp_ov) check("out_data", 64'(o_od), 64'(exp_q[0]));
            if (pop) void'(exp_q.pop_front());
            if (pushed) exp_q.push_back(in_data);
        end
        if (exp_q.size() > m_hwm) m_hwm = exp_q.size();
        if (in_close) m_closed = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        exp_q.delete();
        m_closed = 1'b0;
        m_hwm    = 0;
    endtask

    task automatic do_reset();
        in_valid = 1'b0; in_close = 1'b0; out_ready = 1'b0;
        rst = 1'b0;
        #2;
        clear_model();
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic select(input int s, input int depth, input bit regready);
        sel = s; m_depth = depth; m_regready = regready;
    endtask

    task automatic push_word(input logic [W-1:0] d);
        bit p;
        in_data = d; in_valid = 1'b1;
        tick(p);
        in_valid = 1'b0;
    endtask

    task automatic rand_phase(input int n);
        bit p;
        p = 1'b0;
        in_valid = 1'b0; in_close = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (!in_valid || p) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = $urandom;
            end
            out_ready = $urandom_range(0, 1) != 0;
            tick(p);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick(p);
    endtask

    initial begin
        bit p;
        rst = 1'b0; in_data = '0; in_valid = 1'b0; in_close = 1'b0; out_ready = 1'b0;
        select(0, 4, 1'b1);
        clear_model();
        #2;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check("rst_out_valid", 64'(o_ov), 64'(0));
            check("rst_out_closed", 64'(o_oc), 64'(0));
            check("rst_count", 64'(o_cnt), 64'(0));
            check("rst_in_ready", 64'(o_ir), 64'((s == 2) ? 0 : 1));
        end
        out_ready = 1'b1;
        #1;
        check("rst_rdv_in_ready", 64'(o_ir), 64'(1));
        out_ready = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;

        // DEPTH=4, REG_READY=1: fill, check that a full buffer blocks pushes, then drain in order.
        select(0, 4, 1'b1);
        push_word(32'h11); push_word(32'h22); push_word(32'h33); push_word(32'h44);
        in_data = 32'h55; in_valid = 1'b1; tick(p);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(p);
            if (p) in_valid = 1'b0;
        end
        rand_phase(60);

        // DEPTH=2, REG_READY=0: a full buffer streams at full rate across pointer wrap.
        do_reset();
        select(1, 2, 1'b0);
        push_word(32'ha0); push_word(32'ha1);
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_data = 32'hb0 + 32'(i);
            tick(p);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick(p);
        rand_phase(60);

        // DEPTH=0 rendezvous.
        do_reset();
        select(2, 0, 1'b1);
        in_data = 32'ha5; in_valid = 1'b1; out_ready = 1'b0;
        tick(p);
        out_ready = 1'b1;
        tick(p);
        rand_phase(30);

        // Close travels behind the data: 7, then 9 together with close.
        do_reset();
        select(0, 4, 1'b1);
        push_word(32'd7);
        in_data = 32'd9; in_valid = 1'b1; in_close = 1'b1;
        tick(p);
        in_valid = 1'b0; in_close = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick(p);
        in_valid = 1'b1; in_data = 32'hdead;
        tick(p);
        tick(p);

        // Asynchronous reset in the middle of a cycle while count=3 and the channel is closed.
        do_reset();
        select(0, 4, 1'b1);
        push_word(32'h1); push_word(32'h2); push_word(32'h3);
        in_close = 1'b1; tick(p);
        in_close = 1'b0; tick(p);
        #2 rst = 1'b0;
        #1;
        check("arst_count", 64'(o_cnt), 64'(0));
        check("arst_out_valid", 64'(o_ov), 64'(0));
        check("arst_out_closed", 64'(o_oc), 64'(0));
        clear_model();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        tick(p);

        // High-water mark sequence: push 3, pop 3, push 1.
        do_reset();
        select(0, 4, 1'b1);
        push_word(32'h21); push_word(32'h22); push_word(32'h23);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick(p);
        out_ready = 1'b0;
        push_word(32'h24);
        tick(p);
        rst = 1'b0;
        #1;
`ifdef MYGO_CHAN_HWM_EN
        check("hwm_after_reset", 64'(o_hwm), 64'(0));
`endif
        check("count_after_reset", 64'(o_cnt), 64'(0));
        clear_model();
        #3 rst = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
